// File: rtl/intr_ctrl_n.sv
// ----------------------------------------------------------------------------
// intr_ctrl_n
// Parametrised interrupt controller for the 16-bit multicycle datapath.
// N asynchronous request lines are synchronised and edge-detected. Each edge
// latches a pending flag. The lowest-index pending source that is enabled by
// the mask is presented to the control FSM through an irq / irq_ack / eoi
// handshake, together with its handler vector.
//
// Optional feature macro: INTR_DEBOUNCE_EN
//   When it is defined, each channel gets a debounce counter. The
//   synchronised level must stay stable for DEBOUNCE_CYCLES cycles before the
//   edge detector sees it.
//
// Ports:
//   CLK         system clock, rising edge
//   RST_N       asynchronous active-low reset
//   hw_in       raw request levels, asynchronous to CLK
//   mask_wr     loads mask_data into the mask register
//   mask_data   new mask (1 = source enabled for arbitration)
//   irq         interrupt request to the control FSM
//   irq_ack     FSM accepts the request (pulse)
//   eoi         FSM finished the handler (pulse)
//   vector      handler address of the source in service
//   src_id      index of the source in service
//   pending     pending flags, masked and unmasked
//   in_service  a handler is active
//
// State | meaning
// IDLE  | no request outstanding; arbitrate pending & mask
// REQ   | irq asserted, waiting for irq_ack
// SERVICE | handler running, waiting for eoi
// ----------------------------------------------------------------------------
module intr_ctrl_n #(
    parameter int                N_SRC           = 8,
    parameter int                DATA_W          = 16,
    parameter logic [DATA_W-1:0] VEC_BASE        = DATA_W'(16'h0040),
    parameter int                VEC_STRIDE      = 4,
    parameter int                DEBOUNCE_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [N_SRC-1:0]  hw_in,
    input  logic              mask_wr,
    input  logic [N_SRC-1:0]  mask_data,
    output logic              irq,
    input  logic              irq_ack,
    input  logic              eoi,
    output logic [DATA_W-1:0] vector,
    output logic [3:0]        src_id,
    output logic [N_SRC-1:0]  pending,
    output logic              in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Edge detection is held off until the input pipeline holds real samples,
    // so a line that is high through reset is absorbed rather than reported.
`ifdef INTR_DEBOUNCE_EN
    localparam logic [2:0] WARM_CYCLES = 3'd4;
`else
    localparam logic [2:0] WARM_CYCLES = 3'd3;
`endif

    logic [N_SRC-1:0]  r_sync1;
    logic [N_SRC-1:0]  r_sync2;
    logic [N_SRC-1:0]  r_edge;
    logic [N_SRC-1:0]  r_pending;
    logic [N_SRC-1:0]  r_mask;
    logic [2:0]        r_warm_cnt;
    logic [3:0]        r_src_id;
    logic [DATA_W-1:0] r_vector;
    state_t            r_state;

    logic [N_SRC-1:0]  w_level;
    logic [N_SRC-1:0]  w_rise;
    logic [N_SRC-1:0]  w_req;
    logic [N_SRC-1:0]  w_clr;
    logic [3:0]        w_winner;
    logic [DATA_W-1:0] w_vec_next;
    logic              w_armed;
    logic              w_load;
    logic              w_ack_take;
    state_t            w_state_next;

    assign w_armed = (r_warm_cnt == 3'd0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_warm_cnt <= WARM_CYCLES;
        end else begin
            r_sync1 <= hw_in;
            r_sync2 <= r_sync1;
            if (!w_armed) begin
                r_warm_cnt <= r_warm_cnt - 3'd1;
            end
        end
    end

`ifdef INTR_DEBOUNCE_EN
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES);

    logic [N_SRC-1:0] r_db_lvl;
    logic [DB_W-1:0]  r_db_cnt [N_SRC];

    // The down-counter runs only while the synchronised level differs from
    // the accepted level; any return to the accepted level reloads it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_db_lvl <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                r_db_cnt[i] <= DB_LOAD;
            end
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (!w_armed) begin
                    r_db_lvl[i] <= r_sync2[i];
                    r_db_cnt[i] <= DB_LOAD;
                end else if (r_sync2[i] == r_db_lvl[i]) begin
                    r_db_cnt[i] <= DB_LOAD;
                end else if (r_db_cnt[i] == DB_W'(1)) begin
                    r_db_lvl[i] <= r_sync2[i];
                    r_db_cnt[i] <= DB_LOAD;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] - DB_W'(1);
                end
            end
        end
    end

    assign w_level = r_db_lvl;
`else
    assign w_level = r_sync2;
`endif

    assign w_rise = w_level & ~r_edge & {N_SRC{w_armed}};
    assign w_req  = r_pending & r_mask;

    always_comb begin
        w_winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_winner = 4'(i);
            end
        end
    end

    assign w_vec_next = VEC_BASE + DATA_W'(int'(w_winner) * VEC_STRIDE);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ack_take   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) begin
                    w_load       = 1'b1;
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    w_ack_take   = 1'b1;
                    w_state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_clr[i] = w_ack_take && (r_src_id == 4'(i));
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_edge    <= '0;
            r_pending <= '0;
            r_mask    <= '1;
            r_src_id  <= '0;
            r_vector  <= '0;
        end else begin
            r_state <= w_state_next;
            r_edge  <= w_level;
            // A new edge on the channel being acknowledged keeps it pending.
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_wr) begin
                r_mask <= mask_data;
            end
            if (w_load) begin
                r_src_id <= w_winner;
                r_vector <= w_vec_next;
            end
        end
    end

    assign irq        = (r_state == ST_REQ);
    assign in_service = (r_state == ST_SERVICE);
    assign vector     = r_vector;
    assign src_id     = r_src_id;
    assign pending    = r_pending;

endmodule
